// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, flag-mask indices and FSM states for alu_seq (divider enabled by ALU_SEQ_DIV_EN)
package alu_seq_pkg;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_OR  = 4'h1;
   localparam logic [3:0] OP_XOR = 4'h2;
   localparam logic [3:0] OP_LSL = 4'h3;
   localparam logic [3:0] OP_LSR = 4'h4;
   localparam logic [3:0] OP_ASR = 4'h5;
   localparam logic [3:0] OP_CSL = 4'h6;
   localparam logic [3:0] OP_ADD = 4'h7;
   localparam logic [3:0] OP_SUB = 4'h8;
   localparam logic [3:0] OP_NEG = 4'h9;
   localparam logic [3:0] OP_NOT = 4'hA;
   localparam logic [3:0] OP_MUL = 4'hB;
   localparam logic [3:0] OP_DIV = 4'hC;
   localparam logic [3:0] OP_MOD = 4'hD;
   localparam logic [3:0] OP_TRA = 4'hE;
   localparam logic [3:0] OP_TRB = 4'hF;

   // bit positions inside the 4-bit update mask control[7:4] = {N,Z,C,V}
   localparam int UPD_N = 3;
   localparam int UPD_Z = 2;
   localparam int UPD_C = 1;
   localparam int UPD_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ITER = 2'd2
   } state_t;

   // Opcodes that go through the iterative unit; DIV/MOD only when the divider exists.
   function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
`else
      return (op == OP_MUL);
`endif
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - shift-add multiplier with optional restoring divider (ALU_SEQ_DIV_EN)
module alu_iter_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
`ifdef ALU_SEQ_DIV_EN
   input  logic             div_sel,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             fin,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] hi_nx;
   logic [WIDTH-1:0] lo_nx;
   logic [WIDTH:0]   sum;
`ifdef ALU_SEQ_DIV_EN
   logic             div_q;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_diff;
   logic             rem_ge;
`endif

   assign fin = (cnt == '0);

   // One iteration step: mul adds-then-shifts {hi,lo} right, div shifts left and trial-subtracts.
   always_comb begin
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      rem_sh   = {hi, lo[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, opnd});
      rem_diff = rem_sh[WIDTH-1:0] - opnd;
      if (div_q) begin
         hi_nx = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
         lo_nx = {lo[WIDTH-2:0], rem_ge};
      end
`endif
   end

   // Load operands on issue, then run exactly WIDTH steps.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         hi   <= '0;
         lo   <= '0;
         opnd <= '0;
`ifdef ALU_SEQ_DIV_EN
         div_q <= 1'b0;
`endif
      end else if (load) begin
         cnt <= CW'(WIDTH);
         hi  <= '0;
`ifdef ALU_SEQ_DIV_EN
         div_q <= div_sel;
         lo    <= div_sel ? a : b;
         opnd  <= div_sel ? b : a;
`else
         lo   <= b;
         opnd <= a;
`endif
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
         hi  <= hi_nx;
         lo  <= lo_nx;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked WIDTH-bit ALU with registered NZCV flags (DIV/MOD enabled by ALU_SEQ_DIV_EN)
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [7:0]       control,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic             accept;
   logic             finish;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       op_q;
   logic [3:0]       mask_q;
   logic             it_fin;
   logic [WIDTH-1:0] it_lo;
   logic [WIDTH-1:0] it_hi;

   logic [SHW-1:0]   sh;
   logic [SHW-1:0]   shm1;
   logic [SHW-1:0]   rsh;
   logic             zero_amt;
   logic             in_range;
   logic [WIDTH-1:0] lsl_t;
   logic [WIDTH-1:0] lsr_t;
   logic [WIDTH-1:0] asr_t;
   logic [WIDTH-1:0] rot;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] res;
   logic             c_out;
   logic             v_out;

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (accept),
`ifdef ALU_SEQ_DIV_EN
      .div_sel (control[3:0] != OP_MUL),
`endif
      .a       (in_a),
      .b       (in_b),
      .fin     (it_fin),
      .lo      (it_lo),
      .hi      (it_hi)
   );

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next state; a start seen while done is still high waits one cycle
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !done) begin
               accept   = 1'b1;
               state_nx = is_iter(control[3:0]) ? ITER : EXEC;
            end
         end
         EXEC: begin
            finish   = 1'b1;
            state_nx = IDLE;
         end
         ITER: begin
            if (it_fin) begin
               finish   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Capture operands and control at issue
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         mask_q <= '0;
      end else if (accept) begin
         a_q    <= in_a;
         b_q    <= in_b;
         op_q   <= control[3:0];
         mask_q <= control[7:4];
      end
   end

   // Result and carry/overflow of the latched operation
   always_comb begin
      sh       = b_q[SHW-1:0];
      shm1     = sh - SHW'(1);
      rsh      = SHW'(0) - sh;
      zero_amt = (b_q == '0);
      in_range = ((b_q >> SHW) == '0);
      // pre-shift by amount-1 so the last bit shifted out sits at an edge bit
      lsl_t    = a_q << shm1;
      lsr_t    = a_q >> shm1;
      asr_t    = $signed(a_q) >>> shm1;
      rot      = (a_q << sh) | (a_q >> rsh);
      sum      = {1'b0, a_q} + {1'b0, b_q};
      diff     = a_q - b_q;
      res      = '0;
      c_out    = 1'b0;
      v_out    = 1'b0;
      case (op_q)
         OP_AND: res = a_q & b_q;
         OP_OR:  res = a_q | b_q;
         OP_XOR: res = a_q ^ b_q;
         OP_LSL: begin
            if (zero_amt) res = a_q;
            else if (in_range) begin
               res   = {lsl_t[WIDTH-2:0], 1'b0};
               c_out = lsl_t[WIDTH-1];
            end
         end
         OP_LSR: begin
            if (zero_amt) res = a_q;
            else if (in_range) begin
               res   = {1'b0, lsr_t[WIDTH-1:1]};
               c_out = lsr_t[0];
            end
         end
         OP_ASR: begin
            if (zero_amt) res = a_q;
            else if (in_range) begin
               res   = {asr_t[WIDTH-1], asr_t[WIDTH-1:1]};
               c_out = asr_t[0];
            end else begin
               res   = {WIDTH{a_q[WIDTH-1]}};
               c_out = a_q[WIDTH-1];
            end
         end
         OP_CSL: begin
            res   = rot;
            c_out = zero_amt ? 1'b0 : rot[0];
         end
         OP_ADD: begin
            res   = sum[WIDTH-1:0];
            c_out = sum[WIDTH];
            v_out = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            res   = diff;
            c_out = (a_q < b_q);
            v_out = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_NEG: begin
            res   = -a_q;
            v_out = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_NOT: res = ~a_q;
         OP_MUL: begin
            res   = it_lo;
            c_out = |it_hi;
         end
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            res   = it_lo;
            v_out = (b_q == '0);
         end
         OP_MOD: begin
            res   = it_hi;
            v_out = (b_q == '0);
         end
`endif
         OP_TRA: res = a_q;
         OP_TRB: res = b_q;
         default: res = '0;
      endcase
   end

   // Publish result, masked flags and the done pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done   <= 1'b0;
         result <= '0;
         N      <= 1'b0;
         Z      <= 1'b0;
         C      <= 1'b0;
         V      <= 1'b0;
      end else begin
         done <= finish;
         if (finish) begin
            result <= res;
            if (mask_q[UPD_N]) N <= res[WIDTH-1];
            if (mask_q[UPD_Z]) Z <= (res == '0);
            if (mask_q[UPD_C]) C <= c_out;
            if (mask_q[UPD_V]) V <= v_out;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (vector table, corner sequences, random vs model)
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 16;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    control = '0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          busy, done, N, Z, C, V;
   logic [W-1:0]  result;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [3:0]    m_flags = '0;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  mask;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [3:0]  nzcv;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   alu_seq #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .control (control),
      .in_a    (in_a),
      .in_b    (in_b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .N       (N),
      .Z       (Z),
      .C       (C),
      .V       (V)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [3:0] mask, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] res, input logic [3:0] nzcv,
                               input int lat);
      vec_t t;
      t.op = op; t.mask = mask; t.a = a; t.b = b; t.res = res; t.nzcv = nzcv; t.lat = lat;
      return t;
   endfunction

   function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
      if (op == OP_DIV || op == OP_MOD) return W + 1;
`endif
      return (op == OP_MUL) ? W + 1 : 1;
   endfunction

   // Arithmetic reference on plain integers, 16-bit operands.
   function automatic void ref_op(input logic [3:0] op, input int a, input int b,
                                  output int res, output bit c, output bit v);
      int     sa, sb, t, k;
      longint p;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      res = 0; c = 0; v = 0;
      case (op)
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_LSL: begin
            if (b == 0) res = a;
            else if (b < 16) begin res = (a << b) & 'hFFFF; c = ((a >> (16 - b)) & 1) != 0; end
         end
         OP_LSR: begin
            if (b == 0) res = a;
            else if (b < 16) begin res = a >> b; c = ((a >> (b - 1)) & 1) != 0; end
         end
         OP_ASR: begin
            if (b == 0) res = a;
            else if (b < 16) begin res = (sa >>> b) & 'hFFFF; c = ((sa >>> (b - 1)) & 1) != 0; end
            else begin res = (sa < 0) ? 'hFFFF : 0; c = (sa < 0); end
         end
         OP_CSL: begin
            k = b % 16;
            res = ((a << k) | (a >> (16 - k))) & 'hFFFF;
            c = (b == 0) ? 1'b0 : ((res & 1) != 0);
         end
         OP_ADD: begin
            t = a + b; res = t & 'hFFFF; c = (t >> 16) != 0;
            v = (sa + sb > 32767) || (sa + sb < -32768);
         end
         OP_SUB: begin
            res = (a - b) & 'hFFFF; c = (a < b);
            v = (sa - sb > 32767) || (sa - sb < -32768);
         end
         OP_NEG: begin res = (-a) & 'hFFFF; v = (a == 32768); end
         OP_NOT: res = (~a) & 'hFFFF;
         OP_MUL: begin
            p = longint'(a) * longint'(b);
            res = int'(p & 64'hFFFF); c = (p >> 16) != 0;
         end
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin if (b == 0) begin res = 'hFFFF; v = 1; end else res = a / b; end
         OP_MOD: begin if (b == 0) begin res = a; v = 1; end else res = a % b; end
`endif
         OP_TRA: res = a;
         OP_TRB: res = b;
         default: res = 0;
      endcase
   endfunction

   // Expected result of one op plus the model's flag register after it.
   task automatic model_apply(input logic [3:0] op, input logic [3:0] mask, input logic [15:0] a,
                              input logic [15:0] b, output logic [15:0] er);
      int r;
      bit c, v;
      ref_op(op, int'(a), int'(b), r, c, v);
      er = r[15:0];
      if (mask[3]) m_flags[3] = er[15];
      if (mask[2]) m_flags[2] = (er == 16'h0);
      if (mask[1]) m_flags[1] = c;
      if (mask[0]) m_flags[0] = v;
   endtask

   // Issue one op and wait (bounded) for done; lat counts cycles after the accept edge.
   task automatic run_op(input logic [3:0] op, input logic [3:0] mask, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] res, output logic [3:0] nzcv,
                         output logic [15:0] er, output int lat);
      @(negedge clock);
      control = {mask, op}; in_a = a; in_b = b; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clock);
         lat++;
      end
      res  = result;
      nzcv = {N, Z, C, V};
      model_apply(op, mask, a, b, er);
   endtask

   initial begin
      logic [15:0] res, er, a, b;
      logic [3:0]  nzcv, op, mask;
      int          lat, pulses;

      vecs.push_back(mk(OP_ADD, 4'hF, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1));
      vecs.push_back(mk(OP_LSR, 4'hF, 16'h8001, 16'h0001, 16'h4000, 4'b0010, 1));
      vecs.push_back(mk(OP_ASR, 4'hF, 16'h8000, 16'd20,   16'hFFFF, 4'b1010, 1));
      vecs.push_back(mk(OP_CSL, 4'hF, 16'h8001, 16'd17,   16'h0003, 4'b0010, 1));
      vecs.push_back(mk(OP_MUL, 4'hF, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 17));
      vecs.push_back(mk(OP_AND, 4'hF, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1));
      vecs.push_back(mk(OP_XOR, 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1));
      vecs.push_back(mk(OP_NEG, 4'hF, 16'h8000, 16'h0000, 16'h8000, 4'b1001, 1));
      vecs.push_back(mk(OP_LSL, 4'hF, 16'h0001, 16'd16,   16'h0000, 4'b0100, 1));
      vecs.push_back(mk(OP_LSL, 4'hF, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1));
      vecs.push_back(mk(OP_LSR, 4'hF, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1));
      vecs.push_back(mk(OP_SUB, 4'hF, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1));
      vecs.push_back(mk(OP_TRB, 4'hF, 16'h0000, 16'h8000, 16'h8000, 4'b1000, 1));
      vecs.push_back(mk(OP_MUL, 4'hF, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 17));
`ifdef ALU_SEQ_DIV_EN
      vecs.push_back(mk(OP_DIV, 4'hF, 16'd100,  16'd7,    16'd14,   4'b0000, 17));
      vecs.push_back(mk(OP_MOD, 4'hF, 16'd100,  16'd7,    16'd2,    4'b0000, 17));
      vecs.push_back(mk(OP_DIV, 4'hF, 16'd5,    16'd0,    16'hFFFF, 4'b1001, 17));
      vecs.push_back(mk(OP_MOD, 4'hF, 16'd5,    16'd0,    16'd5,    4'b0001, 17));
`else
      vecs.push_back(mk(OP_DIV, 4'hF, 16'd100,  16'd7,    16'h0000, 4'b0100, 1));
      vecs.push_back(mk(OP_MOD, 4'hF, 16'd100,  16'd7,    16'h0000, 4'b0100, 1));
`endif

      // reset state
      repeat (2) @(negedge clock);
      check("reset_outputs", {8'h0, busy, done, N, Z, C, V, result}, 32'h0);
      reset_n = 1'b1;

      // vector table
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].mask, vecs[i].a, vecs[i].b, res, nzcv, er, lat);
         check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
         check($sformatf("vec%0d_nzcv", i), 32'(nzcv), 32'(vecs[i].nzcv));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // SUB with mask C only: N,Z,V keep the values left by the XOR
      run_op(OP_XOR, 4'hF, 16'hFFFF, 16'hFFFF, res, nzcv, er, lat);
      run_op(OP_SUB, 4'h2, 16'h0003, 16'h0005, res, nzcv, er, lat);
      check("sub_mask_result", 32'(res), 32'hFFFE);
      check("sub_mask_nzcv", 32'(nzcv), 32'b0110);

      // MUL with mask Z,C and start pulses while busy
      run_op(OP_ADD, 4'hF, 16'h7FFF, 16'h0001, res, nzcv, er, lat);
      @(negedge clock);
      control = {4'h6, OP_MUL}; in_a = 16'h0100; in_b = 16'h0100; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("mul_busy", 32'(busy), 32'h1);
      lat = 0;
      while (!done && lat < 100) begin
         if (lat == 3 || lat == 4 || lat == 9) begin
            control = {4'hF, OP_AND}; in_a = '0; in_b = '0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         lat++;
      end
      start = 1'b0;
      model_apply(OP_MUL, 4'h6, 16'h0100, 16'h0100, er);
      check("mul_latency", 32'(lat), 32'd17);
      check("mul_result", 32'(result), 32'h0);
      check("mul_nzcv", 32'({N, Z, C, V}), 32'b1111);

      // back-to-back: start held from the done cycle is taken one cycle later
      control = {4'hF, OP_ADD}; in_a = 16'h0001; in_b = 16'h0002; start = 1'b1;
      @(negedge clock);
      check("b2b_ignored_in_done_cycle", 32'(busy), 32'h0);
      @(negedge clock);
      start = 1'b0;
      check("b2b_accepted", 32'(busy), 32'h1);
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clock);
         lat++;
      end
      model_apply(OP_ADD, 4'hF, 16'h0001, 16'h0002, er);
      check("b2b_latency", 32'(lat), 32'd1);
      check("b2b_result", 32'(result), 32'h3);

      // random ops against the model
      for (int i = 0; i < 200; i++) begin
         op   = 4'($urandom_range(0, 15));
         mask = 4'($urandom_range(0, 15));
         a    = 16'($urandom);
         b    = 16'($urandom);
         if (op == OP_LSL || op == OP_LSR || op == OP_ASR || op == OP_CSL)
            b = 16'($urandom_range(0, 20));
         if ((op == OP_DIV || op == OP_MOD) && $urandom_range(0, 5) == 0)
            b = 16'h0;
         run_op(op, mask, a, b, res, nzcv, er, lat);
         check($sformatf("rnd%0d_op%0h_result", i, op), 32'(res), 32'(er));
         check($sformatf("rnd%0d_op%0h_nzcv", i, op), 32'(nzcv), 32'(m_flags));
         check($sformatf("rnd%0d_op%0h_latency", i, op), 32'(lat), 32'(exp_lat(op)));
      end

      // reset in the middle of MUL 3*5
      @(negedge clock);
      control = {4'hF, OP_MUL}; in_a = 16'd3; in_b = 16'd5; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("midreset_outputs", {8'h0, busy, done, N, Z, C, V, result}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         if (done) pulses++;
      end
      check("midreset_no_done", 32'(pulses), 32'h0);
      check("midreset_idle", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
